mem_port_arbiter: RTL and testbench

//  Shares the single external memory port between three requesters: Icache line refill,

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter_priority_sel.sv | 21 ++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, requester ids and request-vector bit positions.
// Optional starvation guard is enabled with the ARB_STARVE_GUARD_EN macro (see mem_port_arbiter.sv).
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      ARB_ID_IC  = 2'd0,
      ARB_ID_DCR = 2'd1,
      ARB_ID_DCW = 2'd2
   } arb_id_t;

   localparam int unsigned REQ_IC  = 0;
   localparam int unsigned REQ_DCR = 1;
   localparam int unsigned REQ_DCW = 2;
   localparam int unsigned N_REQ   = 3;

   function automatic arb_id_t grant_to_id(input logic [N_REQ-1:0] grant);
      if (grant[REQ_DCW]) return ARB_ID_DCW;
      if (grant[REQ_DCR]) return ARB_ID_DCR;
      return ARB_ID_IC;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter; slave = arbiter side, master = caches/memory side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
);
   logic              ic_read_req;
   logic [ADDR_W-1:0] ic_read_addr;
   logic              ic_read_ack;
   logic [DATA_W-1:0] ic_read_data;
   logic              dc_read_req;
   logic [ADDR_W-1:0] dc_read_addr;
   logic              dc_read_ack;
   logic [DATA_W-1:0] dc_read_data;
   logic              dc_write_req;
   logic [ADDR_W-1:0] dc_write_addr;
   logic [DATA_W-1:0] dc_write_data;
   logic              dc_write_ack;
   logic              mem_enable;
   logic              mem_rw;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
             dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
      output ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
             mem_enable, mem_rw, mem_addr, mem_data_out
   );

   modport master (
      output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr,
             dc_write_req, dc_write_addr, dc_write_data, mem_ack, mem_data_in,
      input  ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack,
             mem_enable, mem_rw, mem_addr, mem_data_out
   );
endinterface

// File: rtl/mem_port_arbiter_priority_sel.sv
// Combinational winner select: dc_write > dc_read > ic_read, unless the starve flag lifts ic_read to the top.
module mem_port_arbiter_priority_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_starve,
   output logic [N_REQ-1:0] o_grant
);
   always_comb begin
      o_grant = '0;
      if (i_starve && i_req[REQ_IC]) begin
         o_grant[REQ_IC] = 1'b1;
      end else if (i_req[REQ_DCW]) begin
         o_grant[REQ_DCW] = 1'b1;
      end else if (i_req[REQ_DCR]) begin
         o_grant[REQ_DCR] = 1'b1;
      end else if (i_req[REQ_IC]) begin
         o_grant[REQ_IC] = 1'b1;
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between Icache refill, Dcache refill and Dcache write-back, one line at a time.
// Define ARB_STARVE_GUARD_EN to let a waiting Icache refill win after STARVE_LIMIT Dcache grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
`ifdef ARB_STARVE_GUARD_EN
   ,
   parameter int unsigned STARVE_LIMIT = 4
`endif
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   arb_state_t        r_state;
   arb_id_t           r_id;
   logic              r_mem_enable;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_data_out;
   logic [DATA_W-1:0] r_ic_data;
   logic [DATA_W-1:0] r_dc_data;
   logic              r_ic_ack;
   logic              r_dcr_ack;
   logic              r_dcw_ack;

   logic [N_REQ-1:0]  w_req;
   logic [N_REQ-1:0]  w_grant;
   logic              w_starve;
   arb_id_t           w_win_id;
   logic [ADDR_W-1:0] w_win_addr;

   assign w_req[REQ_IC]  = bus.ic_read_req;
   assign w_req[REQ_DCR] = bus.dc_read_req;
   assign w_req[REQ_DCW] = bus.dc_write_req;

   mem_port_arbiter_priority_sel u_arb_priority_sel (
      .i_req    (w_req),
      .i_starve (w_starve),
      .o_grant  (w_grant)
   );

   assign w_win_id = grant_to_id(w_grant);

   always_comb begin
      case (w_win_id)
         ARB_ID_DCW: w_win_addr = bus.dc_write_addr;
         ARB_ID_DCR: w_win_addr = bus.dc_read_addr;
         default:    w_win_addr = bus.ic_read_addr;
      endcase
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 2);
   logic [CNT_W-1:0] r_starve_cnt;

   assign w_starve = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

   // Counts Dcache wins that bypassed a waiting Icache refill; any Icache win clears it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_starve_cnt <= '0;
      end else if (r_state == ARB_IDLE && |w_grant) begin
         if (w_grant[REQ_IC]) begin
            r_starve_cnt <= '0;
         end else if (bus.ic_read_req && !w_starve) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign w_starve = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ARB_IDLE;
         r_id           <= ARB_ID_IC;
         r_mem_enable   <= 1'b0;
         r_mem_rw       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_data_out <= '0;
         r_ic_data      <= '0;
         r_dc_data      <= '0;
         r_ic_ack       <= 1'b0;
         r_dcr_ack      <= 1'b0;
         r_dcw_ack      <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (|w_grant) begin
                  r_id         <= w_win_id;
                  r_mem_addr   <= w_win_addr;
                  r_mem_rw     <= (w_win_id == ARB_ID_DCW);
                  r_mem_enable <= 1'b1;
                  if (w_win_id == ARB_ID_DCW) begin
                     r_mem_data_out <= bus.dc_write_data;
                  end
                  r_state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (bus.mem_ack) begin
                  r_mem_enable <= 1'b0;
                  case (r_id)
                     ARB_ID_IC: begin
                        r_ic_data <= bus.mem_data_in;
                        r_ic_ack  <= 1'b1;
                     end
                     ARB_ID_DCR: begin
                        r_dc_data <= bus.mem_data_in;
                        r_dcr_ack <= 1'b1;
                     end
                     default: r_dcw_ack <= 1'b1;
                  endcase
                  r_state <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               r_ic_ack  <= 1'b0;
               r_dcr_ack <= 1'b0;
               r_dcw_ack <= 1'b0;
               r_state   <= ARB_IDLE;
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign bus.ic_read_ack  = r_ic_ack;
   assign bus.ic_read_data = r_ic_data;
   assign bus.dc_read_ack  = r_dcr_ack;
   assign bus.dc_read_data = r_dc_data;
   assign bus.dc_write_ack = r_dcw_ack;
   assign bus.mem_enable   = r_mem_enable;
   assign bus.mem_rw       = r_mem_rw;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_data_out = r_mem_data_out;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected memory transactions and acks,
// a negedge monitor pops and compares them whenever the DUT starts a transaction or pulses an ack.
module tb_mem_port_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 128;
   localparam int ID_IC  = 0;
   localparam int ID_DCR = 1;
   localparam int ID_DCW = 2;
`ifdef ARB_STARVE_GUARD_EN
   localparam int N_DC = 4;
`else
   localparam int N_DC = 6;
`endif

   typedef struct {
      int          id;
      logic [DW-1:0] data;
   } ack_exp_t;

   typedef struct {
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   ack_exp_t      ack_q[$];
   mem_exp_t      mem_q[$];
   logic [DW-1:0] rd_q[$];

   int   mem_lat   = 1;
   bit   mem_auto  = 1'b1;
   bit   stray_ack = 1'b0;
   bit   chk_reset = 1'b0;
   bit   chk_quiet = 1'b0;
   bit   chk_b2b   = 1'b0;
   bit   tb_done   = 1'b0;
   int   n_to      = 0;
   logic [2:0] drop_en = 3'b111;
   logic [2:0] ack_seen = 3'b000;

   always @(posedge clk) ack_seen <= {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};

   // Memory model: acks mem_lat cycles into each transaction, read data taken from rd_q.
   initial begin : mem_model
      int cnt;
      cnt = 0;
      bus.mem_ack     = 1'b0;
      bus.mem_data_in = '0;
      forever begin
         @(negedge clk);
         #1;
         bus.mem_ack = stray_ack;
         if (bus.mem_enable === 1'b1 && mem_auto) begin
            cnt++;
            if (cnt == mem_lat) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_rw === 1'b0 && rd_q.size() > 0) bus.mem_data_in = rd_q.pop_front();
               else bus.mem_data_in = {8{16'hDEAD}};
            end else begin
               bus.mem_data_in = {8{16'hBEEF}};
            end
         end else begin
            cnt = 0;
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_ack_cyc = -100;
   bit prev_en = 1'b0;
   mem_exp_t cur_mem;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic int ack_id(input logic [2:0] a);
      if (a[2]) return ID_DCW;
      if (a[1]) return ID_DCR;
      return ID_IC;
   endfunction

   initial begin : monitor
      logic [2:0] acks;
      ack_exp_t   ea;
      cur_mem = '{1'b0, '0, '0};
      forever begin
         @(negedge clk);
         cyc++;
         acks = {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
         if (chk_reset) begin
            chk("rst_acks", DW'(acks), '0);
            chk("rst_mem_enable", DW'(bus.mem_enable), '0);
            chk("rst_mem_rw", DW'(bus.mem_rw), '0);
            chk("rst_mem_addr", DW'(bus.mem_addr), '0);
            chk("rst_mem_data_out", bus.mem_data_out, '0);
            chk("rst_ic_read_data", bus.ic_read_data, '0);
            chk("rst_dc_read_data", bus.dc_read_data, '0);
         end
         if (chk_quiet) begin
            chk("quiet_acks", DW'(acks), '0);
            chk("quiet_mem_enable", DW'(bus.mem_enable), '0);
         end
         if (bus.mem_enable === 1'b1) begin
            if (!prev_en) begin
               if (mem_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_mem_txn: got addr %0h, required no transaction", bus.mem_addr);
               end else begin
                  cur_mem = mem_q.pop_front();
                  if (chk_b2b) chk("b2b_gap", DW'(cyc - last_ack_cyc), DW'(2));
               end
            end
            chk("mem_rw", DW'(bus.mem_rw), DW'(cur_mem.rw));
            chk("mem_addr", DW'(bus.mem_addr), DW'(cur_mem.addr));
            if (cur_mem.rw) chk("mem_data_out", bus.mem_data_out, cur_mem.wdata);
         end
         prev_en = (bus.mem_enable === 1'b1);
         if (acks !== 3'b000) begin
            last_ack_cyc = cyc;
            chk("ack_onehot", DW'($onehot(acks)), DW'(1));
            chk("ack_after_mem_ack", DW'(bus.mem_ack), DW'(1));
            chk("ack_mem_enable_low", DW'(bus.mem_enable), '0);
            if (ack_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ack: got acks %b, required none", acks);
            end else begin
               ea = ack_q.pop_front();
               chk("ack_id", DW'(ack_id(acks)), DW'(ea.id));
               if (ea.id == ID_IC) chk("ic_read_data", bus.ic_read_data, ea.data);
               else if (ea.id == ID_DCR) chk("dc_read_data", bus.dc_read_data, ea.data);
            end
         end
         if (tb_done) begin
            chk("timeouts", DW'(n_to), '0);
            chk("ack_q_empty", DW'(ack_q.size()), '0);
            chk("mem_q_empty", DW'(mem_q.size()), '0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
         if (cyc > 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL watchdog: got %0d cycles, required test completion", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (ack_seen[0] === 1'b1 && drop_en[0]) bus.ic_read_req  = 1'b0;
      if (ack_seen[1] === 1'b1 && drop_en[1]) bus.dc_read_req  = 1'b0;
      if (ack_seen[2] === 1'b1 && drop_en[2]) bus.dc_write_req = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (ack_q.size() == 0 && mem_q.size() == 0 && bus.mem_enable === 1'b0 &&
             !bus.ic_read_req && !bus.dc_read_req && !bus.dc_write_req) return;
      end
      n_to++;
      $display("FAIL wait_done: timed out after %0d cycles, required idle", budget);
   endtask

   task automatic wait_enable(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (bus.mem_enable === 1'b1) return;
      end
      n_to++;
      $display("FAIL wait_enable: timed out after %0d cycles, required mem_enable", budget);
   endtask

   task automatic exp_read(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      mem_q.push_back(mem_exp_t'{1'b0, addr, '0});
      rd_q.push_back(data);
      ack_q.push_back(ack_exp_t'{id, data});
   endtask

   task automatic exp_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      mem_q.push_back(mem_exp_t'{1'b1, addr, data});
      ack_q.push_back(ack_exp_t'{ID_DCW, '0});
   endtask

   initial begin : stimulus
      bit hit;
      int n_dc;
      bus.ic_read_req   = 1'b0;
      bus.dc_read_req   = 1'b0;
      bus.dc_write_req  = 1'b0;
      bus.ic_read_addr  = '0;
      bus.dc_read_addr  = '0;
      bus.dc_write_addr = '0;
      bus.dc_write_data = '0;

      // Reset held two cycles with every request up; write-back must win first after release.
      rst_n = 1'b0;
      bus.ic_read_addr  = 32'h0000_3000;
      bus.dc_read_addr  = 32'h0000_2000;
      bus.dc_write_addr = 32'h0000_1000;
      bus.dc_write_data = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
      bus.ic_read_req   = 1'b1;
      bus.dc_read_req   = 1'b1;
      bus.dc_write_req  = 1'b1;
      step();
      chk_reset = 1'b1;
      step();
      exp_write(32'h0000_1000, 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004);
      exp_read(ID_DCR, 32'h0000_2000, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      exp_read(ID_IC, 32'h0000_3000, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
      rst_n = 1'b1;
      step();
      chk_reset = 1'b0;
      wait_done(60);

      // Lone Icache refill with a two-cycle memory.
      mem_lat = 2;
      bus.ic_read_addr = 32'h0000_0040;
      exp_read(ID_IC, 32'h0000_0040, {16{8'hA5}});
      bus.ic_read_req = 1'b1;
      wait_done(30);
      mem_lat = 1;

      // Simultaneous write-back and refill: write first, read starts right after the IDLE cycle.
      bus.dc_write_addr = 32'h0000_0100;
      bus.dc_write_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      bus.dc_read_addr  = 32'h0000_0200;
      exp_write(32'h0000_0100, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      exp_read(ID_DCR, 32'h0000_0200, 128'h5A5A_0000_5A5A_1111_5A5A_2222_5A5A_3333);
      bus.dc_write_req = 1'b1;
      bus.dc_read_req  = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack_seen[2] === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         n_to++;
         $display("FAIL wait_write_ack: timed out, required dc_write_ack");
      end
      chk_b2b = 1'b1;
      wait_done(30);
      chk_b2b = 1'b0;

      // Requester withdraws mid-transaction; ack still arrives.
      mem_lat = 3;
      bus.ic_read_addr = 32'h0000_0080;
      exp_read(ID_IC, 32'h0000_0080, 128'h0000_0000_0000_0000_1234_5678_9ABC_DEF0);
      bus.ic_read_req = 1'b1;
      wait_enable(10);
      bus.ic_read_req = 1'b0;
      wait_done(30);
      mem_lat = 1;

      // Stray mem_ack while idle must be ignored.
      chk_quiet = 1'b1;
      stray_ack = 1'b1;
      step();
      stray_ack = 1'b0;
      step();
      step();
      chk_quiet = 1'b0;

      // Reset during BUSY abandons the transaction with no ack.
      mem_auto = 1'b0;
      bus.dc_read_addr = 32'h0000_0500;
      mem_q.push_back(mem_exp_t'{1'b0, 32'h0000_0500, '0});
      bus.dc_read_req = 1'b1;
      wait_enable(10);
      step();
      rst_n = 1'b0;
      bus.dc_read_req = 1'b0;
      step();
      chk_reset = 1'b1;
      chk_quiet = 1'b1;
      rst_n = 1'b1;
      step();
      chk_reset = 1'b0;
      step();
      step();
      chk_quiet = 1'b0;
      mem_auto = 1'b1;

      // Continuous Dcache refills against a waiting Icache refill.
      drop_en[1] = 1'b0;
      bus.dc_read_addr = 32'h0000_0600;
      bus.ic_read_addr = 32'h0000_0700;
      for (int i = 0; i < N_DC; i++) exp_read(ID_DCR, 32'h0000_0600, DW'(32'h6000 + i));
      exp_read(ID_IC, 32'h0000_0700, 128'h7777);
      bus.dc_read_req = 1'b1;
      bus.ic_read_req = 1'b1;
      hit = 1'b0;
      n_dc = 0;
      for (int i = 0; i < 200; i++) begin
         step();
`ifdef ARB_STARVE_GUARD_EN
         if (ack_seen[0] === 1'b1) begin
            bus.dc_read_req = 1'b0;
            hit = 1'b1;
            break;
         end
`else
         if (ack_seen[1] === 1'b1) n_dc++;
         if (n_dc == N_DC) begin
            bus.dc_read_req = 1'b0;
            hit = 1'b1;
            break;
         end
`endif
      end
      if (!hit) begin
         n_to++;
         $display("FAIL starve_seq: timed out, required sequence end");
      end
      wait_done(40);
      drop_en[1] = 1'b1;

      step();
      tb_done = 1'b1;
   end
endmodule
